// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage is the master; it drives requests and MTHI/MTLO writes.
interface muldiv_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One product or quotient bit per cycle on magnitudes; sign fix-up in a single FIX cycle.
module muldiv_unit #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 6
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);
  localparam int unsigned W2 = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic          busyQ;
  logic          doneQ;
  logic          divZeroQ;
  logic [W-1:0]  hiQ;
  logic [W-1:0]  loQ;

  logic [CW-1:0] cnt;
  logic [W-1:0]  accHi;
  logic [W-1:0]  accLo;
  logic [W-1:0]  opnd;
  logic          isDiv;
  logic          negQ;
  logic          negR;
  logic          divZeroPend;

  logic          accept;
  logic          resultWrite;
  logic          isSignedIn;
  logic          isDivIn;
  logic [W-1:0]  magA;
  logic [W-1:0]  magB;
  logic [W:0]    mulSum;
  logic [W:0]    divShift;
  logic          divBit;
  logic [W-1:0]  divRem;
  logic [W2-1:0] prod;
  logic [W2-1:0] prodFix;
  logic [W-1:0]  resHi;
  logic [W-1:0]  resLo;

  assign bus.busy     = busyQ;
  assign bus.done     = doneQ;
  assign bus.div_zero = divZeroQ;
  assign bus.hi       = hiQ;
  assign bus.lo       = loQ;

  // Operand magnitudes at accept time
  always_comb begin
    isSignedIn = ~bus.op[0];
    isDivIn    = bus.op[1];
    magA       = (isSignedIn && bus.a[W-1]) ? (~bus.a + W'(1)) : bus.a;
    magB       = (isSignedIn && bus.b[W-1]) ? (~bus.b + W'(1)) : bus.b;
  end

  // State register; busy/done are registered copies of the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      state <= stateNext;
      busyQ <= (stateNext != IDLE);
      doneQ <= (stateNext == DONE);
    end
  end

  always_comb begin
    stateNext   = state;
    accept      = 1'b0;
    resultWrite = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          stateNext = CALC;
          accept    = 1'b1;
        end
      end
      CALC: begin
        if (bus.cancel)                 stateNext = IDLE;
        else if (cnt == CW'(W - 1))     stateNext = FIX;
      end
      FIX: begin
        if (bus.cancel) begin
          stateNext = IDLE;
        end else begin
          stateNext   = DONE;
          resultWrite = 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // One shift-add or restoring-subtract step
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : (W + 1)'(0));
    divShift = {accHi, accLo[W-1]};
    divBit   = (divShift >= {1'b0, opnd});
    divRem   = divBit ? W'(divShift - {1'b0, opnd}) : divShift[W-1:0];
  end

  // Sign fix-up; a zero divisor leaves the dividend magnitude in accHi, so the
  // remainder fix-up restores the raw dividend for HI
  always_comb begin
    prod    = {accHi, accLo};
    prodFix = negQ ? (~prod + W2'(1)) : prod;
    if (isDiv) begin
      resHi = negR ? (~accHi + W'(1)) : accHi;
      if (divZeroPend) resLo = '1;
      else             resLo = negQ ? (~accLo + W'(1)) : accLo;
    end else begin
      resHi = prodFix[W2-1:W];
      resLo = prodFix[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      accHi       <= '0;
      accLo       <= '0;
      opnd        <= '0;
      isDiv       <= 1'b0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      divZeroPend <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      accHi       <= '0;
      accLo       <= isDivIn ? magA : magB;
      opnd        <= isDivIn ? magB : magA;
      isDiv       <= isDivIn;
      negQ        <= isSignedIn & (bus.a[W-1] ^ bus.b[W-1]);
      negR        <= isSignedIn & isDivIn & bus.a[W-1];
      divZeroPend <= isDivIn && (bus.b == '0);
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (isDiv) begin
        accHi <= divRem;
        accLo <= {accLo[W-2:0], divBit};
      end else begin
        accHi <= mulSum[W:1];
        accLo <= {mulSum[0], accLo[W-1:1]};
      end
    end
  end

  // HI/LO: completed result takes priority over MTHI/MTLO on the same edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hiQ      <= '0;
      loQ      <= '0;
      divZeroQ <= 1'b0;
    end else if (resultWrite) begin
      hiQ      <= resHi;
      loQ      <= resLo;
      divZeroQ <= divZeroPend;
    end else begin
      if (bus.hi_we) hiQ <= bus.wdata;
      if (bus.lo_we) loQ <= bus.wdata;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (W=32).
module tb_muldiv_unit;
  localparam int unsigned W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  muldiv_if #(.W(W)) bus ();

  muldiv_unit #(.W(W), .CW(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one op and follow it to one cycle past done
  task automatic doOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      output int lat, output int busyCyc);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    lat       = 0;
    busyCyc   = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      step(1);
      lat++;
      if (bus.busy) busyCyc++;
    end
    step(1);
    if (bus.busy) busyCyc++;
  endtask

  task automatic countDones(input int n, output int d);
    d = 0;
    repeat (n) begin
      step(1);
      if (bus.done) d++;
    end
  endtask

  task automatic test_reset;
    resetn     = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    step(3);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_divzero got %b exp 0", bus.div_zero); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    resetn = 1'b1;
    step(1);
  endtask

  task automatic test_mult;
    int lat, bc;
    doOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (bc !== 34) begin failures++; $display("FAIL mult_busy_cycles got %0d exp 34", bc); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo got %h exp fffffff1", bus.lo); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got %b exp 0", bus.done); end

    doOp(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bc);
    checks++; if (bus.hi !== 32'h4000_0000) begin failures++; $display("FAIL mult_min_hi got %h exp 40000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL mult_min_lo got %h exp 0", bus.lo); end
  endtask

  task automatic test_multu;
    int lat, bc;
    doOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL multu_latency got %0d exp 33", lat); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
  endtask

  task automatic test_div;
    int lat, bc;
    doOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++; if (bc !== 34) begin failures++; $display("FAIL div_busy_cycles got %0d exp 34", bc); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got %h exp ffffffff", bus.hi); end

    doOp(OP_DIVU, 32'd100, 32'd7, lat, bc);
    checks++; if (bus.lo !== 32'h0000_000E) begin failures++; $display("FAIL divu_lo got %h exp 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_0002) begin failures++; $display("FAIL divu_hi got %h exp 00000002", bus.hi); end

    doOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if (bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got %h exp 0", bus.hi); end
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL div_ovf_dz got %b exp 0", bus.div_zero); end
  endtask

  task automatic test_divzero;
    int lat, bc;
    doOp(OP_DIVU, 32'h0000_1234, 32'h0, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL dz_latency got %0d exp 33", lat); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_lo got %h exp ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_1234) begin failures++; $display("FAIL dz_hi got %h exp 00001234", bus.hi); end
    checks++; if (bus.div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag_hold got %b exp 1", bus.div_zero); end

    doOp(OP_DIV, 32'hFFFF_FFFB, 32'h0, lat, bc);
    checks++; if (bus.hi !== 32'hFFFF_FFFB) begin failures++; $display("FAIL dz_signed_hi got %h exp fffffffb", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_signed_lo got %h exp ffffffff", bus.lo); end

    doOp(OP_MULT, 32'd2, 32'd3, lat, bc);
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL dz_clear got %b exp 0", bus.div_zero); end
    checks++; if (bus.lo !== 32'd6) begin failures++; $display("FAIL dz_next_lo got %h exp 00000006", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL dz_next_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_cancel;
    int d;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_00AA;
    step(1);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0055;
    step(1);
    bus.lo_we = 1'b0;
    checks++; if (bus.hi !== 32'h0000_00AA) begin failures++; $display("FAIL mthi got %h exp 000000aa", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0055) begin failures++; $display("FAIL mtlo got %h exp 00000055", bus.lo); end

    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(10);
    bus.cancel = 1'b1;
    step(1);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0000_00AA) begin failures++; $display("FAIL cancel_hi got %h exp 000000aa", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0055) begin failures++; $display("FAIL cancel_lo got %h exp 00000055", bus.lo); end
    countDones(40, d);
    checks++; if (d !== 0) begin failures++; $display("FAIL cancel_no_done got %0d exp 0", d); end

    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    step(1);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_with_cancel got %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int d;
    bus.op    = OP_MULTU;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(4);
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    step(10);
    bus.start = 1'b0;
    countDones(60, d);
    checks++; if (d !== 1) begin failures++; $display("FAIL busy_start_dones got %0d exp 1", d); end
    checks++; if (bus.lo !== 32'd42) begin failures++; $display("FAIL busy_start_lo got %h exp 0000002a", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL busy_start_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_reset_mid;
    int d;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0011;
    step(1);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.op    = OP_MULTU;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(5);
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
    step(1);
    resetn = 1'b1;
    countDones(40, d);
    checks++; if (d !== 0) begin failures++; $display("FAIL rstmid_no_done got %0d exp 0", d); end
  endtask

  task automatic test_mtlo_collision;
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(3);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0077;
    step(1);
    bus.lo_we = 1'b0;
    checks++; if (bus.lo !== 32'h0000_0077) begin failures++; $display("FAIL mtlo_busy got %h exp 00000077", bus.lo); end
    step(W - 4);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL fix_state got done=%b busy=%b exp done=0 busy=1", bus.done, bus.busy);
    end
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    step(1);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL coll_done got %b exp 1", bus.done); end
    checks++; if (bus.lo !== 32'h0000_000E) begin failures++; $display("FAIL coll_lo got %h exp 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_0002) begin failures++; $display("FAIL coll_hi got %h exp 00000002", bus.hi); end
    step(1);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL coll_idle got %b exp 0", bus.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_mtlo_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
